// File: rtl/audio_pkg.sv
// Shared types and constants for the multichannel delay line and its sample RAM.
package audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int BRAM_LATENCY = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fsm_state_t;

endpackage

// File: rtl/delay_bram.sv
// Simple dual-port sample RAM: port A writes, port B reads through two output registers.
module delay_bram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 14,
  parameter int WORDS  = 12288
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdReg_q;
  logic [WIDTH-1:0] rdOut_q;

  // No reset on purpose so the array and both read stages map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rdReg_q <= mem[rd_addr_i];
    rdOut_q <= rdReg_q;
  end

  assign rd_data_o = rdOut_q;

endmodule

// File: rtl/multichannel_delay_line.sv
// Per-channel sample delay sharing one time-multiplexed RAM, with cold-start masking,
// bypass, overrun flag and a summed mix output.
module multichannel_delay_line
  import audio_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4096,
  parameter int DELAY_W = $clog2(DEPTH)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 enable_delay,
  input  logic                                 audio_valid_in,
  input  logic [NUM_CH*WIDTH-1:0]              audio_in,
  input  logic [NUM_CH*DELAY_W-1:0]            delay_in,
  output logic [NUM_CH*WIDTH-1:0]              audio_out,
  output logic signed [WIDTH+$clog2(NUM_CH)-1:0] mix_out,
  output logic                                 valid_out,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = CH_W + DELAY_W;
  localparam int MIX_W  = WIDTH + $clog2(NUM_CH);
  localparam int FILL_W = DELAY_W + 1;

  fsm_state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;

  logic [NUM_CH*WIDTH-1:0]   audioLat_q;
  logic [NUM_CH*DELAY_W-1:0] delayLat_q;
  logic                      enLat_q;
  logic [DELAY_W-1:0]        wrPtr_q;
  logic [FILL_W-1:0]         fill_q;

  logic             pipeVld_q [BRAM_LATENCY];
  logic [CH_W-1:0]  pipeCh_q  [BRAM_LATENCY];
  logic signed [WIDTH-1:0] stage_q [NUM_CH];

  logic [NUM_CH*WIDTH-1:0] audioOut_q;
  logic signed [MIX_W-1:0] mix_q;
  logic valid_q, busy_q, overrun_q;

  logic [DELAY_W-1:0] issueDelay, rdOffset, landDelay;
  logic [WIDTH-1:0]   rdData;
  logic               landVld, loadOut;
  logic [CH_W-1:0]    landCh;
  logic signed [WIDTH-1:0] landIn, landSample, chSample;
  logic [NUM_CH*WIDTH-1:0] outNext;
  logic signed [MIX_W-1:0] mixSum;

  // A DELAY_W-bit delay can never exceed DEPTH-1, so the read never collides with the write.
  assign issueDelay = delayLat_q[int'(ch_q)*DELAY_W +: DELAY_W];
  assign rdOffset   = wrPtr_q - issueDelay;

  delay_bram #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .WORDS (NUM_CH*DEPTH)
  ) u_bram (
    .clk_i    (clk_in),
    .we_i     (state_q == ISSUE),
    .wr_addr_i({ch_q, wrPtr_q}),
    .wr_data_i(audioLat_q[int'(ch_q)*WIDTH +: WIDTH]),
    .rd_addr_i({ch_q, rdOffset}),
    .rd_data_o(rdData)
  );

  assign landVld   = pipeVld_q[BRAM_LATENCY-1];
  assign landCh    = pipeCh_q[BRAM_LATENCY-1];
  assign landDelay = delayLat_q[int'(landCh)*DELAY_W +: DELAY_W];
  assign landIn    = audioLat_q[int'(landCh)*WIDTH +: WIDTH];
  assign loadOut   = landVld && (landCh == CH_W'(NUM_CH-1));

  // Bypass and zero delay pass the live sample; unwritten history reads as silence.
  always_comb begin
    landSample = rdData;
    if (!enLat_q || landDelay == '0) begin
      landSample = landIn;
    end else if (FILL_W'(landDelay) > fill_q) begin
      landSample = '0;
    end
  end

  always_comb begin
    outNext  = '0;
    mixSum   = '0;
    chSample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chSample = (c == NUM_CH-1) ? landSample : stage_q[c];
      outNext[c*WIDTH +: WIDTH] = chSample;
      mixSum = mixSum + MIX_W'(chSample);
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (audio_valid_in) begin
          state_d = ISSUE;
          ch_d    = '0;
        end
      end
      ISSUE: begin
        if (ch_q == CH_W'(NUM_CH-1)) begin
          state_d = DRAIN;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DRAIN: begin
        if (ch_q == CH_W'(BRAM_LATENCY-1)) begin
          state_d = DONE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      audioLat_q <= '0;
      delayLat_q <= '0;
      enLat_q    <= 1'b0;
      wrPtr_q    <= '0;
      fill_q     <= '0;
      audioOut_q <= '0;
      mix_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        pipeVld_q[i] <= 1'b0;
        pipeCh_q[i]  <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        stage_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (audio_valid_in && state_q == IDLE) begin
        audioLat_q <= audio_in;
        delayLat_q <= delay_in;
        enLat_q    <= enable_delay;
        busy_q     <= 1'b1;
      end else if (audio_valid_in) begin
        overrun_q <= 1'b1;
      end
      pipeVld_q[0] <= (state_q == ISSUE);
      pipeCh_q[0]  <= ch_q;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        pipeVld_q[i] <= pipeVld_q[i-1];
        pipeCh_q[i]  <= pipeCh_q[i-1];
      end
      if (landVld) begin
        stage_q[landCh] <= landSample;
      end
      valid_q <= loadOut;
      if (loadOut) begin
        audioOut_q <= outNext;
        mix_q      <= mixSum;
        busy_q     <= 1'b0;
        wrPtr_q    <= wrPtr_q + 1'b1;
        if (fill_q != FILL_W'(DEPTH)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  assign audio_out = audioOut_q;
  assign mix_out   = mix_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Randomized and directed checks of the delay line against a sample-history model.
module tb_multichannel_delay_line;

  localparam int NUM_CH  = 3;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int DELAY_W = 4;
  localparam int MIX_W   = 18;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic enable_delay = 1'b1;
  logic audio_valid_in = 1'b0;
  logic [NUM_CH*WIDTH-1:0]   audio_in = '0;
  logic [NUM_CH*DELAY_W-1:0] delay_in = '0;
  logic [NUM_CH*WIDTH-1:0]   audio_out;
  logic signed [MIX_W-1:0]   mix_out;
  logic valid_out, busy, overrun;

  int checks = 0;
  int errors = 0;

  int curIn  [NUM_CH];
  int curDly [NUM_CH];
  bit curEn;
  int hist [NUM_CH][512];
  int histCnt = 0;
  int lastOut [NUM_CH];
  int lastMix;

  multichannel_delay_line #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DELAY_W(DELAY_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable_delay  (enable_delay),
    .audio_valid_in(audio_valid_in),
    .audio_in      (audio_in),
    .delay_in      (delay_in),
    .audio_out     (audio_out),
    .mix_out       (mix_out),
    .valid_out     (valid_out),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in  = 1'b0;
    histCnt = 0;
  endtask

  // One frame: strobe, optional stray strobe / reset at a given cycle, then check vs the model.
  task automatic applyStimulus(input int extraAt, input int rstAt);
    int expOut [NUM_CH];
    int expMix;
    int lat;
    int validCnt;
    expMix = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!curEn || curDly[c] == 0)    expOut[c] = curIn[c];
      else if (curDly[c] > histCnt)    expOut[c] = 0;
      else                             expOut[c] = hist[c][histCnt - curDly[c]];
      expMix += expOut[c];
      audio_in[c*WIDTH +: WIDTH]     = WIDTH'(curIn[c]);
      delay_in[c*DELAY_W +: DELAY_W] = DELAY_W'(curDly[c]);
    end
    enable_delay   = curEn;
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    audio_in       = 48'({$urandom(), $urandom()});
    delay_in       = 12'($urandom());
    enable_delay   = 1'($urandom_range(0, 1));
    lat      = 0;
    validCnt = 0;
    for (int cyc = 1; cyc <= NUM_CH + 12; cyc++) begin
      if (cyc == 1) checkOutput("busy_start", busy, 1);
      if (valid_out) begin
        validCnt++;
        if (lat == 0) begin
          lat = cyc;
          checkOutput("busy_done", busy, 0);
          for (int c = 0; c < NUM_CH; c++) begin
            lastOut[c] = int'($signed(audio_out[c*WIDTH +: WIDTH]));
            checkOutput($sformatf("out_ch%0d", c), $signed(audio_out[c*WIDTH +: WIDTH]), expOut[c]);
          end
          lastMix = int'(mix_out);
          checkOutput("mix", mix_out, expMix);
        end
      end
      audio_valid_in = (cyc == extraAt);
      rst_in         = (cyc == rstAt);
      @(negedge clk_in);
    end
    audio_valid_in = 1'b0;
    rst_in         = 1'b0;
    if (rstAt == 0) begin
      checkOutput("latency", lat, NUM_CH + 3);
      checkOutput("valid_pulses", validCnt, 1);
      for (int c = 0; c < NUM_CH; c++) hist[c][histCnt] = curIn[c];
      histCnt++;
    end else begin
      checkOutput("valid_after_reset", validCnt, 0);
      checkOutput("out_after_reset", audio_out, 0);
      checkOutput("mix_after_reset", mix_out, 0);
      checkOutput("busy_after_reset", busy, 0);
      checkOutput("overrun_after_reset", overrun, 0);
      histCnt = 0;
    end
  endtask

  initial begin
    doReset();
    checkOutput("reset_out", audio_out, 0);
    checkOutput("reset_mix", mix_out, 0);
    checkOutput("reset_valid", valid_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);

    $display("[TB] zero-delay frame");
    curIn = '{1, 2, 3}; curDly = '{0, 0, 0}; curEn = 1'b1;
    applyStimulus(0, 0);
    checkOutput("basic_mix", lastMix, 6);

    $display("[TB] cold start");
    doReset();
    curDly = '{1, 5, 10};
    for (int n = 0; n < 12; n++) begin
      curIn = '{n, n, n};
      applyStimulus(0, 0);
      if (n == 1) begin
        checkOutput("cold2_ch0", lastOut[0], 0);
        checkOutput("cold2_ch1", lastOut[1], 0);
        checkOutput("cold2_ch2", lastOut[2], 0);
      end
      if (n == 10) begin
        checkOutput("cold11_ch0", lastOut[0], 9);
        checkOutput("cold11_ch1", lastOut[1], 5);
        checkOutput("cold11_ch2", lastOut[2], 0);
      end
    end

    $display("[TB] pointer wrap");
    doReset();
    curDly = '{15, 15, 15};
    for (int n = 0; n < 40; n++) begin
      curIn = '{n, n + 100, n - 50};
      applyStimulus(0, 0);
      if (n == 16 || n == 32 || n == 39) checkOutput("wrap_ch0", lastOut[0], n - 15);
    end

    $display("[TB] random frames");
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        curIn[c]  = int'($signed(16'($urandom())));
        curDly[c] = $urandom_range(0, DEPTH - 1);
      end
      curEn = ($urandom_range(0, 3) != 0);
      applyStimulus(0, 0);
    end

    $display("[TB] extremes");
    curIn = '{-32768, -32768, -32768}; curDly = '{0, 0, 0}; curEn = 1'b1;
    applyStimulus(0, 0);
    checkOutput("extreme_mix", lastMix, -98304);
    curDly = '{DEPTH - 1, DEPTH - 1, DEPTH - 1};
    applyStimulus(0, 0);

    $display("[TB] overrun");
    curIn = '{111, -222, 333}; curDly = '{2, 3, 4};
    applyStimulus(2, 0);
    checkOutput("overrun_set", overrun, 1);
    curIn = '{7, 8, 9}; curDly = '{1, 1, 1};
    applyStimulus(0, 0);
    checkOutput("overrun_after_dropped", lastOut[0], 111);
    checkOutput("overrun_sticky", overrun, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 3);
    curIn = '{40, 41, 42}; curDly = '{1, 1, 1};
    applyStimulus(0, 0);
    checkOutput("post_reset_cold", lastOut[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
